// File: rtl/vader_pkg.sv
// Shared definitions for the candidate matcher: state encoding and default widths.
package vader_pkg;

    localparam int unsigned CAND_W_DEFAULT = 128;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT      = 3'd2,
        ST_CMP       = 3'd3,
        ST_FOUND     = 3'd4,
        ST_EXHAUSTED = 3'd5
    } matcher_state_t;

endpackage

// File: rtl/candidate_matcher.sv
// Drives an external candidate generator, compares each candidate against a loaded
// target and stops on the first match or when the generator reports exhaustion.
module candidate_matcher
    import vader_pkg::*;
#(
    parameter int unsigned CAND_W      = CAND_W_DEFAULT,
    parameter int unsigned GEN_LATENCY = 2,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              target_load,
    input  logic [CAND_W-1:0] target_in,
    output logic              gen_next,
    input  logic [CAND_W-1:0] candidate,
    input  logic              gen_exhausted,
    output logic              busy,
    output logic              found,
    output logic              done,
    output logic [CAND_W-1:0] match_word,
    output logic [CNT_W-1:0]  attempts
);

    matcher_state_t    r_state;
    logic [3:0]        r_wait;
    logic [CAND_W-1:0] r_target;
    logic [CAND_W-1:0] r_match_word;
    logic [CNT_W-1:0]  r_attempts;
    logic              r_gen_next;
    logic              r_busy;
    logic              r_found;
    logic              r_done;

    logic w_accept_start;
    logic w_accept_load;
    logic w_match;
    logic w_last_wait;

    assign w_accept_start = start && !r_busy;
    assign w_accept_load  = target_load && !r_busy;
    assign w_match        = (candidate == r_target);
    assign w_last_wait    = (r_wait == 4'(GEN_LATENCY - 1));

    // Status outputs are registered alongside the state so they never glitch on inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wait       <= '0;
            r_target     <= '0;
            r_match_word <= '0;
            r_attempts   <= '0;
            r_gen_next   <= 1'b0;
            r_busy       <= 1'b0;
            r_found      <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_gen_next <= 1'b0;

            if (w_accept_load) begin
                r_target <= target_in;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept_start) begin
                        r_state    <= ST_REQ;
                        r_attempts <= '0;
                        r_gen_next <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end

                ST_REQ: begin
                    r_state <= ST_WAIT;
                    r_wait  <= '0;
                end

                ST_WAIT: begin
                    r_wait <= r_wait + 1'b1;
                    if (w_last_wait) begin
                        r_state <= ST_CMP;
                    end
                end

                ST_CMP: begin
                    if (r_attempts != '1) begin
                        r_attempts <= r_attempts + 1'b1;
                    end
                    // A match on the final candidate takes priority over exhaustion.
                    if (w_match) begin
                        r_state      <= ST_FOUND;
                        r_match_word <= candidate;
                        r_busy       <= 1'b0;
                        r_found      <= 1'b1;
                        r_done       <= 1'b1;
                    end else if (gen_exhausted) begin
                        r_state <= ST_EXHAUSTED;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state    <= ST_REQ;
                        r_gen_next <= 1'b1;
                    end
                end

                ST_FOUND, ST_EXHAUSTED: begin
                    if (w_accept_start) begin
                        r_state    <= ST_REQ;
                        r_attempts <= '0;
                        r_gen_next <= 1'b1;
                        r_busy     <= 1'b1;
                        r_found    <= 1'b0;
                        r_done     <= 1'b0;
                    end else if (w_accept_load) begin
                        r_state <= ST_IDLE;
                        r_found <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_found <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign gen_next   = r_gen_next;
    assign busy       = r_busy;
    assign found      = r_found;
    assign done       = r_done;
    assign match_word = r_match_word;
    assign attempts   = r_attempts;

endmodule

// File: tb/tb_candidate_matcher.sv
// Directed bench for candidate_matcher: a list-driven generator model feeds candidates,
// and expected search outcomes are queued at start and checked when done rises.
module tb_candidate_matcher;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         target_load = 1'b0;
    logic [127:0] target_in = '0;
    logic         gen_next;
    logic [127:0] candidate = '0;
    logic         gen_exhausted = 1'b0;
    logic         busy;
    logic         found;
    logic         done;
    logic [127:0] match_word;
    logic [31:0]  attempts;

    // Second instance with a narrow counter, fed a never-matching candidate stream.
    logic         rst2 = 1'b1;
    logic         start2 = 1'b0;
    logic         gen_next2;
    logic         busy2;
    logic         found2;
    logic         done2;
    logic [127:0] match_word2;
    logic [3:0]   attempts2;
    logic [127:0] cand2 = 128'h1;
    logic [127:0] tgt2 = '0;
    logic         zero_bit = 1'b0;

    candidate_matcher #(.CAND_W(128), .GEN_LATENCY(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .target_load(target_load),
        .target_in(target_in), .gen_next(gen_next), .candidate(candidate),
        .gen_exhausted(gen_exhausted), .busy(busy), .found(found), .done(done),
        .match_word(match_word), .attempts(attempts)
    );

    candidate_matcher #(.CAND_W(128), .GEN_LATENCY(2), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst2), .start(start2), .target_load(zero_bit),
        .target_in(tgt2), .gen_next(gen_next2), .candidate(cand2),
        .gen_exhausted(zero_bit), .busy(busy2), .found(found2), .done(done2),
        .match_word(match_word2), .attempts(attempts2)
    );

    always #5 clk = ~clk;

    // Generator model: each gen_next pulse presents the next list entry,
    // with exhaustion flagged alongside the last one.
    logic [127:0] gen_list[$];
    int           gen_base = 0;
    int           gen_pulses = 0;
    int           gk;

    always @(posedge clk) begin
        if (gen_next) begin
            gk = gen_pulses - gen_base;
            if (gk < gen_list.size()) candidate <= gen_list[gk];
            else                      candidate <= '0;
            gen_exhausted <= (gk >= gen_list.size() - 1);
            gen_pulses    <= gen_pulses + 1;
        end
    end

    typedef struct {
        logic         found;
        logic [127:0] word;
        logic [31:0]  att;
        int           pulses;
        int           lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_list(input logic [127:0] l[$]);
        gen_list = l;
        gen_base = gen_pulses;
    endtask

    // Called #1 after an edge; pulses start, then counts edges until done (bounded).
    task automatic run_search(input int limit, output int cyc);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < limit) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("done_timeout", 128'(done), 128'(1'b1));
    endtask

    task automatic score(input string tag, input int cyc);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 128'(0), 128'(1));
        end else begin
            e = exp_q.pop_front();
            check({tag, "_found"},   128'(found), 128'(e.found));
            check({tag, "_done"},    128'(done), 128'(1'b1));
            check({tag, "_busy"},    128'(busy), 128'(1'b0));
            check({tag, "_attempts"}, 128'(attempts), 128'(e.att));
            check({tag, "_pulses"},  128'(gen_pulses - gen_base), 128'(e.pulses));
            check({tag, "_latency"}, 128'(cyc), 128'(e.lat));
            if (e.found) check({tag, "_word"}, match_word, e.word);
        end
    endtask

    initial begin
        int cyc;
        int p0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_found", 128'(found), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_gen_next", 128'(gen_next), 128'(0));
        check("rst_attempts", 128'(attempts), 128'(0));
        check("rst_match_word", match_word, 128'(0));
        check("rst_sat_attempts", 128'(attempts2), 128'(0));
        rst = 1'b0;
        rst2 = 1'b0;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;

        // Match on the third candidate.
        target_in = 128'h41;
        target_load = 1'b1;
        @(posedge clk); #1;
        target_load = 1'b0;
        load_list('{128'h3F, 128'h40, 128'h41});
        exp_q.push_back('{1'b1, 128'h41, 32'd3, 3, 12});
        run_search(100, cyc);
        score("match3", cyc);

        // Exhaustion after four non-matching candidates, restarted from FOUND.
        load_list('{128'h1, 128'h2, 128'h3, 128'h4});
        exp_q.push_back('{1'b0, 128'h0, 32'd4, 4, 16});
        run_search(100, cyc);
        score("exhaust", cyc);

        // Match on the candidate that also carries the exhaustion flag.
        load_list('{128'h5, 128'h41});
        exp_q.push_back('{1'b1, 128'h41, 32'd2, 2, 8});
        run_search(100, cyc);
        score("match_last", cyc);

        // Reset during the WAIT of the second iteration.
        load_list('{128'h9, 128'hA, 128'hB, 128'hC, 128'hD});
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_pre_busy", 128'(busy), 128'(1));
        check("midrst_pre_pulses", 128'(gen_pulses - gen_base), 128'(2));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_attempts", 128'(attempts), 128'(0));
        check("midrst_done", 128'(done), 128'(0));
        p0 = gen_pulses;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_no_pulse", 128'(gen_pulses - p0), 128'(0));
        check("midrst_idle_busy", 128'(busy), 128'(0));

        // Simultaneous load+start from IDLE, then both re-driven during CMP.
        load_list('{128'h7, 128'h41});
        target_in = 128'h41;
        target_load = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        target_load = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("ignore_busy_in_cmp", 128'(busy), 128'(1));
        target_in = 128'hFF;
        target_load = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        target_load = 1'b0;
        start = 1'b0;
        cyc = 4;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        exp_q.push_back('{1'b1, 128'h41, 32'd2, 2, 8});
        score("ignore", cyc);

        // Accepted target_load in FOUND returns to IDLE.
        target_in = 128'h55;
        target_load = 1'b1;
        @(posedge clk); #1;
        target_load = 1'b0;
        check("tload_found", 128'(found), 128'(0));
        check("tload_done", 128'(done), 128'(0));
        check("tload_busy", 128'(busy), 128'(0));
        p0 = gen_pulses;
        repeat (6) @(posedge clk);
        #1;
        check("tload_idle_no_pulse", 128'(gen_pulses - p0), 128'(0));

        // Narrow counter has long since passed 20 compares.
        repeat (40) @(posedge clk);
        #1;
        check("sat_attempts_a", 128'(attempts2), 128'(15));
        check("sat_busy", 128'(busy2), 128'(1));
        repeat (4) @(posedge clk);
        #1;
        check("sat_attempts_b", 128'(attempts2), 128'(15));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
